mem_rd_arbiter: RTL and testbench

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_rd_arbiter_pkg.sv | 18 +
 rtl/mem_rd_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_rd_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types for the ICache/DCache read arbiter: FSM states, bus owner, AXI read IDs.
package mem_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [3:0] ARID_I = 4'd0;
    localparam logic [3:0] ARID_D = 4'd1;

endpackage

// File: rtl/mem_rd_arbiter.sv
// Purpose: arbitrates ICache and DCache refill reads onto one AXI read port, one burst in flight.
// Latency: grant registered in IDLE, arvalid the next cycle; return data is combinational from rdata.
// Backpressure: arvalid/addr held until arready; rready high only in DATA; one idle cycle between bursts.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        I_RdReq,
    input  logic [31:0] I_RdAddr,
    input  logic [7:0]  I_RdLen,
    output logic        I_RdAck,
    output logic        I_RetValid,
    output logic        I_RetLast,
    input  logic        D_RdReq,
    input  logic [31:0] D_RdAddr,
    input  logic [7:0]  D_RdLen,
    output logic        D_RdAck,
    output logic        D_RetValid,
    output logic        D_RetLast,
    input  logic        WrBufEmpty,
    output logic [31:0] RetData,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [3:0]  arid,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic        rlast
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_e        r_state;
    owner_e        r_owner;
    logic [31:0]   r_addr;
    logic [7:0]    r_len;
    logic [SW-1:0] r_starve;

    logic          w_d_elig;
    logic          w_i_elig;
    logic          w_grant;
    owner_e        w_pick;
    logic          w_in_data;

    // D normally wins; I is forced through once D has won STARVE_LIMIT contended rounds.
    function automatic owner_e f_pick(input logic d_elig, input logic i_elig,
                                      input logic [SW-1:0] starve);
        if (i_elig && (!d_elig || starve == STARVE_MAX))
            return OWN_I;
        return OWN_D;
    endfunction

    function automatic logic [SW-1:0] f_next_starve(input owner_e pick, input logic i_req,
                                                    input logic [SW-1:0] starve);
        if (pick == OWN_I)
            return '0;
        if (i_req && starve != STARVE_MAX)
            return starve + 1'b1;
        return starve;
    endfunction

    always_comb begin
        w_d_elig  = D_RdReq && WrBufEmpty;
        w_i_elig  = I_RdReq;
        w_grant   = (r_state == ST_IDLE) && (w_d_elig || w_i_elig);
        w_pick    = f_pick(w_d_elig, w_i_elig, r_starve);
        w_in_data = (r_state == ST_DATA);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_I;
            r_addr   <= '0;
            r_len    <= '0;
            r_starve <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_pick;
                        r_addr   <= (w_pick == OWN_I) ? I_RdAddr : D_RdAddr;
                        r_len    <= (w_pick == OWN_I) ? I_RdLen  : D_RdLen;
                        r_starve <= f_next_starve(w_pick, I_RdReq, r_starve);
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready)
                        r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (rvalid && rlast)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        arvalid    = (r_state == ST_ADDR);
        araddr     = r_addr;
        arlen      = r_len;
        arid       = (r_owner == OWN_D) ? ARID_D : ARID_I;
        rready     = w_in_data;
        RetData    = rdata;
        I_RdAck    = arvalid && arready && (r_owner == OWN_I);
        D_RdAck    = arvalid && arready && (r_owner == OWN_D);
        I_RetValid = w_in_data && rvalid && (r_owner == OWN_I);
        D_RetValid = w_in_data && rvalid && (r_owner == OWN_D);
        I_RetLast  = I_RetValid && rlast;
        D_RetLast  = D_RetValid && rlast;
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: AXI slave driven from the main sequence, return beats scoreboarded.
module tb_mem_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        I_RdReq, D_RdReq, WrBufEmpty;
    logic [31:0] I_RdAddr, D_RdAddr;
    logic [7:0]  I_RdLen, D_RdLen;
    logic        I_RdAck, I_RetValid, I_RetLast;
    logic        D_RdAck, D_RetValid, D_RetLast;
    logic [31:0] RetData;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [3:0]  arid;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    // {is_d, last, data}
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    mem_rd_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .resetn(resetn),
        .I_RdReq(I_RdReq), .I_RdAddr(I_RdAddr), .I_RdLen(I_RdLen),
        .I_RdAck(I_RdAck), .I_RetValid(I_RetValid), .I_RetLast(I_RetLast),
        .D_RdReq(D_RdReq), .D_RdAddr(D_RdAddr), .D_RdLen(D_RdLen),
        .D_RdAck(D_RdAck), .D_RetValid(D_RetValid), .D_RetLast(D_RetLast),
        .WrBufEmpty(WrBufEmpty), .RetData(RetData),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every owner beat the bench drove must reappear on the right requester, in order.
    always @(negedge clk) begin
        logic [33:0] e;
        #3;
        if (I_RetValid === 1'b1 || D_RetValid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("ret_unexpected", {I_RetValid, D_RetValid}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("ret_owner", {I_RetValid, D_RetValid}, e[33] ? 2'b01 : 2'b10);
                chk("ret_data", RetData, e[31:0]);
                chk("ret_last", {I_RetLast, D_RetLast},
                    e[32] ? (e[33] ? 2'b01 : 2'b10) : 2'b00);
            end
        end
    end

    // Acts as the AXI slave for one burst; entered and left at negedge+1.
    task automatic serve(input logic is_d, input logic [31:0] addr, input logic [7:0] len,
                         input int delay, input bit drop, input int abort_beat);
        int n;
        logic [31:0] d;
        logic [3:0]  exp_id;
        exp_id = is_d ? 4'd1 : 4'd0;
        n = 0;
        while (arvalid !== 1'b1 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ar_wait", arvalid, 1);
        if (arvalid !== 1'b1) return;
        chk("arid", arid, exp_id);
        chk("araddr", araddr, addr);
        chk("arlen", arlen, len);
        for (int k = 0; k < delay; k++) begin
            chk("ack_early", {I_RdAck, D_RdAck}, 2'b00);
            @(negedge clk); #1;
            chk("ar_hold", {arvalid, araddr, arlen, arid}, {1'b1, addr, len, exp_id});
        end
        arready = 1'b1;
        #1;
        chk("rdack", {I_RdAck, D_RdAck}, is_d ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        arready = 1'b0;
        if (drop) begin
            if (is_d) D_RdReq = 1'b0;
            else      I_RdReq = 1'b0;
        end
        @(negedge clk); #1;
        chk("ar_drop", {arvalid, I_RdAck, D_RdAck}, 3'b000);
        chk("rready", rready, 1);
        for (int b = 0; b <= int'(len); b++) begin
            d      = $urandom;
            rvalid = 1'b1;
            rdata  = d;
            rlast  = (b == int'(len));
            if (b == abort_beat) begin
                resetn = 1'b0;
                #1;
                chk("rst_abort", {arvalid, rready, I_RetValid, D_RetValid, I_RetLast,
                                  D_RetLast, I_RdAck, D_RdAck}, 8'h00);
                rvalid = 1'b0;
                rlast  = 1'b0;
                return;
            end
            sb.push_back({is_d, rlast, d});
            @(negedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("bubble_idle", {arvalid, rready}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        I_RdReq = 1'b0; D_RdReq = 1'b0; WrBufEmpty = 1'b1;
        I_RdAddr = '0; D_RdAddr = '0; I_RdLen = '0; D_RdLen = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;

        // reset state, including a request presented while reset is held
        @(negedge clk); #1;
        chk("reset_outputs", {arvalid, rready, araddr, arlen, arid, I_RdAck, D_RdAck,
                              I_RetValid, D_RetValid, I_RetLast, D_RetLast}, 0);
        I_RdReq = 1'b1;
        @(negedge clk); #1;
        chk("reset_hold", {arvalid, rready}, 2'b00);
        I_RdReq = 1'b0;
        resetn = 1'b1;
        @(negedge clk); #1;

        // lone I refill, arready after two wait cycles
        I_RdAddr = 32'h1FC0_0000; I_RdLen = 8'd7; I_RdReq = 1'b1;
        serve(1'b0, 32'h1FC0_0000, 8'd7, 2, 1'b1, -1);

        // single-beat D read
        D_RdAddr = 32'h8000_0040; D_RdLen = 8'd0; D_RdReq = 1'b1;
        serve(1'b1, 32'h8000_0040, 8'd0, 0, 1'b1, -1);

        // simultaneous requests: D first, I after the bubble
        I_RdAddr = 32'h1FC0_0100; I_RdLen = 8'd3; I_RdReq = 1'b1;
        D_RdAddr = 32'h8000_1000; D_RdLen = 8'd1; D_RdReq = 1'b1;
        serve(1'b1, 32'h8000_1000, 8'd1, 1, 1'b1, -1);
        serve(1'b0, 32'h1FC0_0100, 8'd3, 0, 1'b1, -1);

        // D blocked by a non-empty write buffer
        WrBufEmpty = 1'b0;
        D_RdAddr = 32'h8000_2000; D_RdLen = 8'd2; D_RdReq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("wrbuf_block", arvalid, 0);
        end
        WrBufEmpty = 1'b1;
        @(negedge clk); #1;
        chk("wrbuf_grant", {arvalid, arid}, {1'b1, 4'd1});
        serve(1'b1, 32'h8000_2000, 8'd2, 0, 1'b1, -1);

        // both requesters continuous: D,D,D,I,D,D,D,I
        I_RdAddr = 32'h1FC0_0200; I_RdLen = 8'd2; I_RdReq = 1'b1;
        D_RdAddr = 32'h8000_3000; D_RdLen = 8'd1; D_RdReq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i % 4) != 3) serve(1'b1, 32'h8000_3000, 8'd1, i % 3, 1'b0, -1);
            else              serve(1'b0, 32'h1FC0_0200, 8'd2, i % 3, 1'b0, -1);
        end
        I_RdReq = 1'b0;
        D_RdReq = 1'b0;
        @(negedge clk); #1;

        // starve count reaches the limit, then reset mid-burst must clear it
        D_RdLen = 8'd7; I_RdReq = 1'b1; D_RdReq = 1'b1;
        serve(1'b1, 32'h8000_3000, 8'd7, 0, 1'b0, -1);
        serve(1'b1, 32'h8000_3000, 8'd7, 0, 1'b0, -1);
        serve(1'b1, 32'h8000_3000, 8'd7, 1, 1'b0, 2);
        @(negedge clk); #1;
        chk("rst_hold", {arvalid, rready, I_RetValid, D_RetValid, I_RdAck, D_RdAck}, 6'h00);
        resetn = 1'b1;
        D_RdLen = 8'd0;
        serve(1'b1, 32'h8000_3000, 8'd0, 0, 1'b1, -1);
        serve(1'b0, 32'h1FC0_0200, 8'd2, 0, 1'b1, -1);

        repeat (3) @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
